// File: rtl/multdiv_seq.sv
// rtl/multdiv_seq.sv - start/count/capture sequencer for the iterative multiply and divide datapaths
// Optional: define MULTDIV_DIVOVF_EN to short-circuit 32'h80000000 / -1 as an exception.
module multdiv_seq #(
  parameter int DIV_DONE  = 32,
  parameter int MULT_DONE = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic [5:0]  dp_count,
  output logic [31:0] dp_opA,
  output logic [31:0] dp_opB,
  output logic        dp_sel,
  input  logic [31:0] dp_result,
  input  logic        dp_mult_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] DIV_DONE_C  = 6'(DIV_DONE);
  localparam logic [5:0] MULT_DONE_C = 6'(MULT_DONE);
  localparam logic [5:0] COUNT_IDLE  = 6'h3F;

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] opa_q, opa_d, opb_q, opb_d;
  logic        sel_q, sel_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;
  logic        rdy_q, rdy_d;

  logic        start;
  logic        div_fast;
  logic [31:0] fast_result;
  logic [5:0]  done_cnt;

  assign start    = ctrl_DIV | ctrl_MULT;
  assign done_cnt = sel_q ? DIV_DONE_C : MULT_DONE_C;

`ifdef MULTDIV_DIVOVF_EN
  logic div_ovf;
  assign div_ovf     = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
  assign div_fast    = ctrl_DIV && ((data_operandB == 32'd0) || div_ovf);
  assign fast_result = div_ovf ? 32'h8000_0000 : 32'd0;
`else
  assign div_fast    = ctrl_DIV && (data_operandB == 32'd0);
  assign fast_result = 32'd0;
`endif

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    sel_d    = sel_q;
    result_d = result_q;
    exc_d    = exc_q;
    rdy_d    = 1'b0;

    unique case (state_q)
      IDLE: count_d = COUNT_IDLE;
      RUN: begin
        if (count_q == done_cnt) begin
          result_d = dp_result;
          exc_d    = sel_q ? 1'b0 : dp_mult_ovf;
          rdy_d    = 1'b1;
          state_d  = DONE;
          count_d  = done_cnt + 6'd1;
        end else begin
          count_d = count_q + 6'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = COUNT_IDLE;
      end
      default: begin
        state_d = IDLE;
        count_d = COUNT_IDLE;
      end
    endcase

    // A new pulse always wins, discarding any capture the aborted operation would have made.
    if (start) begin
      opa_d    = data_operandA;
      opb_d    = data_operandB;
      sel_d    = ctrl_DIV;
      result_d = result_q;
      exc_d    = exc_q;
      rdy_d    = 1'b0;
      if (div_fast) begin
        state_d  = DONE;
        count_d  = DIV_DONE_C + 6'd1;
        result_d = fast_result;
        exc_d    = 1'b1;
        rdy_d    = 1'b1;
      end else begin
        state_d = RUN;
        count_d = 6'd0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= COUNT_IDLE;
      opa_q    <= 32'd0;
      opb_q    <= 32'd0;
      sel_q    <= 1'b0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sel_q    <= sel_d;
      result_q <= result_d;
      exc_q    <= exc_d;
      rdy_q    <= rdy_d;
    end
  end

  assign dp_count       = count_q;
  assign dp_opA         = opa_q;
  assign dp_opB         = opb_q;
  assign dp_sel         = sel_q;
  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_multdiv_seq.sv
// tb/tb_multdiv_seq.sv - scoreboard bench for multdiv_seq with a behavioural datapath stand-in
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception, data_resultRDY;
  logic [5:0]  dp_count;
  logic [31:0] dp_opA, dp_opB;
  logic        dp_sel;
  logic [31:0] dp_result;
  logic        dp_mult_ovf;

  multdiv_seq dut (
    .clock(clock), .reset(reset),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .dp_count(dp_count), .dp_opA(dp_opA), .dp_opB(dp_opB), .dp_sel(dp_sel),
    .dp_result(dp_result), .dp_mult_ovf(dp_mult_ovf)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Datapath stand-in: only the exact completion count carries a valid answer.
  logic [63:0] prod;
  assign prod = {32'd0, dp_opA} * {32'd0, dp_opB};
  always_comb begin
    dp_result   = 32'hBAD0_0000 | {26'd0, dp_count};
    dp_mult_ovf = 1'b1;
    if (dp_sel) begin
      if (dp_count == 6'd32 && dp_opB != 32'd0) dp_result = dp_opA / dp_opB;
    end else if (dp_count == 6'd16) begin
      dp_result   = prod[31:0];
      dp_mult_ovf = |prod[63:32];
    end
  end

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void ref_op(input logic d, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e, output int lat);
    logic [63:0] p;
    if (d) begin
      if (b == 32'd0) begin
        r = 32'd0; e = 1'b1; lat = 1;
      end
`ifdef MULTDIV_DIVOVF_EN
      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        r = 32'h8000_0000; e = 1'b1; lat = 1;
      end
`endif
      else begin
        r = a / b; e = 1'b0; lat = 34;
      end
    end else begin
      p = {32'd0, a} * {32'd0, b};
      r = p[31:0]; e = |p[63:32]; lat = 18;
    end
  endfunction

  function automatic void drop_future(input int t);
    for (int i = sbq.size() - 1; i >= 0; i--)
      if (sbq[i].due > t) sbq.delete(i);
  endfunction

  // Pulse is sampled on the edge ending cycle T; returns at the negedge of cycle T+1.
  task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   lat;
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    drop_future(cyc);
    ref_op(d, a, b, e.res, e.exc, lat);
    e.due = cyc + lat;
    sbq.push_back(e);
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  always @(negedge clock) begin
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      exp_t e;
      e = sbq.pop_front();
      chk("rdy", {31'd0, data_resultRDY}, 32'd1);
      chk("result", data_result, e.res);
      chk("exception", {31'd0, data_exception}, {31'd0, e.exc});
    end else if (data_resultRDY) begin
      n_cmp++;
      n_fail++;
      $display("FAIL spurious_rdy: got 1 expected 0 (cycle %0d)", cyc);
    end
  end

  initial begin
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = 32'd0;
    data_operandB = 32'd0;
    repeat (2) @(negedge clock);
    chk("reset_count", {26'd0, dp_count}, 32'h3F);
    chk("reset_result", data_result, 32'd0);
    chk("reset_exc_rdy_sel", {29'd0, data_exception, data_resultRDY, dp_sel}, 32'd0);
    chk("reset_opA", dp_opA, 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // Divide 100/7 with full count trace.
    issue(1'b0, 1'b1, 32'd100, 32'd7);
    chk("div_count_0", {26'd0, dp_count}, 32'd0);
    for (int k = 1; k <= 34; k++) begin
      @(negedge clock);
      chk("div_count_trace", {26'd0, dp_count}, (k <= 32) ? k : (k == 33 ? 33 : 32'h3F));
    end

    // Multiply with overflow.
    issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    repeat (20) @(negedge clock);

    // Divide by zero fast path.
    issue(1'b0, 1'b1, 32'd55, 32'd0);
    chk("dbz_count", {26'd0, dp_count}, 32'd33);
    repeat (3) @(negedge clock);

    // Divide aborted by multiply ten cycles later.
    issue(1'b0, 1'b1, 32'd1000, 32'd3);
    repeat (8) @(negedge clock);
    issue(1'b1, 1'b0, 32'd3, 32'd5);
    repeat (25) @(negedge clock);

    // Both pulses together: divide wins.
    issue(1'b1, 1'b1, 32'd81, 32'd9);
    chk("both_sel", {31'd0, dp_sel}, 32'd1);
    chk("both_opA", dp_opA, 32'd81);
    repeat (36) @(negedge clock);

    // Most-negative / -1.
    issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (36) @(negedge clock);

    // New pulse landing in the DONE cycle.
    issue(1'b1, 1'b0, 32'd7, 32'd6);
    repeat (16) @(negedge clock);
    issue(1'b1, 1'b0, 32'd11, 32'd13);
    repeat (20) @(negedge clock);

    // Reset held three cycles mid-RUN.
    issue(1'b0, 1'b1, 32'd500, 32'd4);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    drop_future(cyc);
    @(negedge clock);
    chk("rst_mid_count", {26'd0, dp_count}, 32'h3F);
    chk("rst_mid_result", data_result, 32'd0);
    chk("rst_mid_flags", {29'd0, data_exception, data_resultRDY, dp_sel}, 32'd0);
    chk("rst_mid_opB", dp_opB, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);

    // Randomised mix, including aborts from short gaps.
    for (int n = 0; n < 40; n++) begin
      logic        m, d;
      logic [31:0] a, b;
      int          sel;
      sel = $urandom_range(0, 9);
      d = (sel < 5);
      m = !d || (sel == 0);
      a = $urandom();
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom() : 32'($urandom_range(1, 300)));
      if (sel == 1) begin
        a = 32'h8000_0000;
        b = 32'hFFFF_FFFF;
      end
      if (!d) b = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 65535));
      issue(m, d, a, b);
      repeat ($urandom_range(0, 38)) @(negedge clock);
    end
    repeat (40) @(negedge clock);
    chk("scoreboard_drained", sbq.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
